// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel bundle type and player sprite geometry.
// Imported by every stage of the pixel pipeline.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 8;
  localparam int PLAYER_Y = 560;

  localparam logic [11:0] PLAYER_RGB = 12'h0_f_0;

  localparam int X_CENTRE = (HOR_PIXELS - SPRITE_W) / 2;
  localparam int X_MAX = HOR_PIXELS - SPRITE_W;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  function automatic logic [10:0] clamp_x(
    input logic [10:0] x,
    input logic [10:0] x_max
  );
    return (x > x_max) ? x_max : x;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle passed between pipeline stages.
// Upstream drives through modport out, downstream samples through in.
interface vga_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, vsync, vblnk,
    input hcount, hsync, hblnk,
    input rgb
  );

  modport out (
    output vcount, vsync, vblnk,
    output hcount, hsync, hblnk,
    output rgb
  );

endinterface

// File: rtl/player_rom.sv
// Player cannon bitmap, one row per address, MSB is the leftmost pixel.
// Synchronous read: data is valid one clock after addr.
module player_rom (
  input  logic        clk,
  input  logic [2:0]  addr,
  output logic [15:0] data
);

  always_ff @(posedge clk) begin
    case (addr)
      3'd0:    data <= 16'h0180;
      3'd1:    data <= 16'h03C0;
      3'd2:    data <= 16'h03C0;
      3'd3:    data <= 16'h7FFE;
      default: data <= 16'hFFFF;
    endcase
  end

endmodule

// File: rtl/draw_player.sv
// Overlays the player cannon on the rgb stream with a fixed 2-cycle delay.
// Horizontal position is double-buffered and swapped on the vblnk rising edge.
module draw_player #(
  parameter int          SPRITE_W   = vga_pkg::SPRITE_W,
  parameter int          SPRITE_H   = vga_pkg::SPRITE_H,
  parameter int          PLAYER_Y   = vga_pkg::PLAYER_Y,
  parameter logic [11:0] PLAYER_RGB = vga_pkg::PLAYER_RGB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] xpos,
  input  logic        xpos_valid,
  vga_if.in           vga_in,
  vga_if.out          vga_out
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  localparam logic [10:0] X_C =
    11'((vga_pkg::HOR_PIXELS - SPRITE_W) / 2);
  localparam logic [10:0] X_M =
    11'(vga_pkg::HOR_PIXELS - SPRITE_W);

  localparam logic [11:0] Y_TOP = 12'(PLAYER_Y);
  localparam logic [11:0] Y_BOT = 12'(PLAYER_Y + SPRITE_H - 1);
  localparam logic [11:0] W_M1 = 12'(SPRITE_W - 1);

  vga_pkg::vga_t px;
  vga_pkg::vga_t s1;
  vga_pkg::vga_t s2;

  logic [10:0] shadow_x;
  logic [10:0] active_x;
  logic        vblnk_q;
  logic        vblnk_rise;

  logic [11:0] h12;
  logic [11:0] v12;
  logic [11:0] x_lo;
  logic [11:0] x_hi;
  logic        hit;
  logic [10:0] hdiff;
  logic [10:0] vdiff;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             s1_hit;
  logic [COL_W-1:0] s1_col;
  logic [COL_W-1:0] bit_idx;
  logic [15:0]      rom_data;
  logic [11:0]      rgb_nxt;

  always_comb begin
    px = '{
      vcount: vga_in.vcount,
      vsync:  vga_in.vsync,
      vblnk:  vga_in.vblnk,
      hcount: vga_in.hcount,
      hsync:  vga_in.hsync,
      hblnk:  vga_in.hblnk,
      rgb:    vga_in.rgb
    };
  end

  assign vblnk_rise = px.vblnk & ~vblnk_q;

  // active takes the pre-update shadow when both happen in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x <= X_C;
      active_x <= X_C;
      vblnk_q  <= 1'b0;
    end else begin
      if (xpos_valid) begin
        shadow_x <= vga_pkg::clamp_x(xpos, X_M);
      end
      if (vblnk_rise) begin
        active_x <= shadow_x;
      end
      vblnk_q <= px.vblnk;
    end
  end

  // 12-bit compares so active_x + W - 1 cannot wrap
  always_comb begin
    h12   = {1'b0, px.hcount};
    v12   = {1'b0, px.vcount};
    x_lo  = {1'b0, active_x};
    x_hi  = x_lo + W_M1;
    hit   = (h12 >= x_lo) && (h12 <= x_hi) &&
            (v12 >= Y_TOP) && (v12 <= Y_BOT) &&
            !px.hblnk && !px.vblnk;
    hdiff = px.hcount - active_x;
    vdiff = px.vcount - 11'(PLAYER_Y);
    col   = hdiff[COL_W-1:0];
    row   = vdiff[ROW_W-1:0];
  end

  player_rom u_rom (
    .clk  (clk),
    .addr (3'(row)),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s1_hit <= 1'b0;
      s1_col <= '0;
    end else begin
      s1     <= px;
      s1_hit <= hit;
      s1_col <= col;
    end
  end

  assign bit_idx = COL_W'(SPRITE_W - 1) - s1_col;

  always_comb begin
    rgb_nxt = s1.rgb;
    if (s1_hit && rom_data[bit_idx]) begin
      rgb_nxt = PLAYER_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      s2     <= s1;
      s2.rgb <= rgb_nxt;
    end
  end

  assign vga_out.vcount = s2.vcount;
  assign vga_out.vsync  = s2.vsync;
  assign vga_out.vblnk  = s2.vblnk;
  assign vga_out.hcount = s2.hcount;
  assign vga_out.hsync  = s2.hsync;
  assign vga_out.hblnk  = s2.hblnk;
  assign vga_out.rgb    = s2.rgb;

endmodule
